perceptron_accum_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 12x3-bit Wallace popcount adder. Each beat reduces N_OPS unsigned OP_W-bit operands through a registered compression tree. Beat sums are accumulated across a multi-beat packet, terminated by in_last, to form one neuron's weighted sum. The block then emits the saturated sum, a threshold-compare fire bit, an overflow flag and a beat count over a valid/ready stream. It sits between the weight/input-product array and the neuron activation logic.

---
 rtl/perceptron_accum_pipe_if.sv | 30 +++
 rtl/perceptron_accum_pipe.sv | 164 ++++++++++++++++
 tb/tb_perceptron_accum_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_accum_pipe_if.sv
// Stream bundle for perceptron_accum_pipe: operand beats in, one packet result out.
// The producer/consumer side takes master and the accumulator takes slave.
interface perceptron_accum_pipe_if #(
  parameter int N_OPS  = 12,
  parameter int OP_W   = 3,
  parameter int SUM_W  = 12,
  parameter int BEAT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OPS*OP_W-1:0]   in_ops;
  logic                    in_last;
  logic [SUM_W-1:0]        in_thresh;
  logic                    out_valid;
  logic                    out_ready;
  logic [SUM_W-1:0]        out_sum;
  logic                    out_fire;
  logic                    out_ovf;
  logic [BEAT_W-1:0]       out_beats;

  modport master (
    output in_valid, in_ops, in_last, in_thresh, out_ready,
    input  in_ready, out_valid, out_sum, out_fire, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_ops, in_last, in_thresh, out_ready,
    output in_ready, out_valid, out_sum, out_fire, out_ovf, out_beats
  );
endinterface

// File: rtl/perceptron_accum_pipe.sv
// Pipelined N_OPS-operand adder tree feeding a saturating per-packet accumulator
// that reports sum, threshold fire, overflow and beat count per packet.
module perceptron_accum_pipe #(
  parameter int N_OPS  = 12,
  parameter int OP_W   = 3,
  parameter int SUM_W  = 12,
  parameter int BEAT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  perceptron_accum_pipe_if.slave  bus
);
  localparam int TREE_W     = OP_W + $clog2(N_OPS);
  localparam int LEVELS     = $clog2(N_OPS);
  localparam int LEAVES     = 1 << LEVELS;
  localparam int HALF_LEVEL = LEVELS - 1;

  typedef enum logic {IDLE, BUSY} state_t;

  genvar gi, gj;

  logic adv;
  logic in_ready;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign in_ready     = adv && !reset;
  assign bus.in_ready = in_ready;

  // Binary tree up to the last level that still has two nodes; the final
  // add of those two partials gets its own register stage.
  generate
    for (gi = 0; gi <= HALF_LEVEL; gi++) begin : g_lvl
      localparam int NODES = LEAVES >> gi;
      logic [NODES-1:0][TREE_W-1:0] node;
      for (gj = 0; gj < NODES; gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          if (gj < N_OPS) begin : g_op
            assign node[gj] = {{(TREE_W-OP_W){1'b0}}, bus.in_ops[gj*OP_W +: OP_W]};
          end else begin : g_pad
            assign node[gj] = '0;
          end
        end else begin : g_add
          assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
        end
      end
    end
  endgenerate

  logic                   s0_valid_reg;
  logic [1:0][TREE_W-1:0] s0_part_reg;
  logic                   s0_last_reg;
  logic [SUM_W-1:0]       s0_thresh_reg;
  logic                   s1_valid_reg;
  logic [TREE_W-1:0]      s1_sum_reg;
  logic                   s1_last_reg;
  logic [SUM_W-1:0]       s1_thresh_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_reg  <= 1'b0;
      s0_part_reg   <= '0;
      s0_last_reg   <= 1'b0;
      s0_thresh_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_sum_reg    <= '0;
      s1_last_reg   <= 1'b0;
      s1_thresh_reg <= '0;
    end else if (adv) begin
      s0_valid_reg  <= bus.in_valid && in_ready;
      s0_part_reg   <= g_lvl[HALF_LEVEL].node;
      s0_last_reg   <= bus.in_last;
      s0_thresh_reg <= bus.in_thresh;
      s1_valid_reg  <= s0_valid_reg;
      s1_sum_reg    <= s0_part_reg[0] + s0_part_reg[1];
      s1_last_reg   <= s0_last_reg;
      s1_thresh_reg <= s0_thresh_reg;
    end
  end

  state_t              state_reg, state_next;
  logic [SUM_W-1:0]    acc_reg, acc_next;
  logic                ovf_reg, ovf_next;
  logic [BEAT_W-1:0]   cnt_reg, cnt_next;
  logic                out_valid_reg, out_valid_next;
  logic [SUM_W-1:0]    out_sum_reg, out_sum_next;
  logic                out_fire_reg, out_fire_next;
  logic                out_ovf_reg, out_ovf_next;
  logic [BEAT_W-1:0]   out_beats_reg, out_beats_next;

  logic [SUM_W-1:0]    acc_base;
  logic [SUM_W:0]      acc_wide;
  logic [SUM_W-1:0]    acc_sat;
  logic                ovf_acc;
  logic [BEAT_W-1:0]   cnt_base;
  logic [BEAT_W-1:0]   cnt_inc;

  // One spare bit on the add exposes the carry that triggers saturation.
  assign acc_base = (state_reg == IDLE) ? '0 : acc_reg;
  assign acc_wide = {1'b0, acc_base} + {{(SUM_W+1-TREE_W){1'b0}}, s1_sum_reg};
  assign acc_sat  = acc_wide[SUM_W] ? {SUM_W{1'b1}} : acc_wide[SUM_W-1:0];
  assign ovf_acc  = ((state_reg == BUSY) && ovf_reg) || acc_wide[SUM_W];
  assign cnt_base = (state_reg == IDLE) ? '0 : cnt_reg;
  assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + BEAT_W'(1);

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg && !bus.out_ready;
    out_sum_next   = out_sum_reg;
    out_fire_next  = out_fire_reg;
    out_ovf_next   = out_ovf_reg;
    out_beats_next = out_beats_reg;
    if (adv && s1_valid_reg) begin
      if (s1_last_reg) begin
        out_valid_next = 1'b1;
        out_sum_next   = acc_sat;
        out_fire_next  = acc_sat >= s1_thresh_reg;
        out_ovf_next   = ovf_acc;
        out_beats_next = cnt_inc;
        state_next     = IDLE;
        acc_next       = '0;
        ovf_next       = 1'b0;
        cnt_next       = '0;
      end else begin
        state_next = BUSY;
        acc_next   = acc_sat;
        ovf_next   = ovf_acc;
        cnt_next   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_fire_reg  <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_beats_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_fire_reg  <= out_fire_next;
      out_ovf_reg   <= out_ovf_next;
      out_beats_reg <= out_beats_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_fire  = out_fire_reg;
  assign bus.out_ovf   = out_ovf_reg;
  assign bus.out_beats = out_beats_reg;
endmodule

// File: tb/tb_perceptron_accum_pipe.sv
// Bench for perceptron_accum_pipe: directed table, multi-cycle sequences and a
// random sweep scored against a packet-level arithmetic model.
module tb_perceptron_accum_pipe;
  localparam int N_OPS   = 12;
  localparam int OP_W    = 3;
  localparam int SUM_W   = 12;
  localparam int BEAT_W  = 8;
  localparam int SUM_W_B = 8;
  localparam int BEAT_W_B = 2;
  localparam int OPS_W   = N_OPS * OP_W;
  localparam longint SUM_MAX  = (longint'(1) << SUM_W) - 1;
  localparam longint BEAT_MAX = (longint'(1) << BEAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  perceptron_accum_pipe_if #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W), .BEAT_W(BEAT_W)) a_if ();
  perceptron_accum_pipe_if #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W_B), .BEAT_W(BEAT_W_B)) b_if ();

  perceptron_accum_pipe #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W), .BEAT_W(BEAT_W)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  perceptron_accum_pipe #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W_B), .BEAT_W(BEAT_W_B)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  typedef struct { longint sum; longint fire; longint ovf; longint beats; } res_t;
  typedef struct { int v; int thresh; int exp_sum; int exp_fire; int exp_ovf; int exp_beats; } vec_t;

  int     total = 0;
  int     bad = 0;
  res_t   exp_q[$];
  longint pkt_total = 0;
  longint pkt_beats = 0;
  bit     ready_rand = 0;
  bit     stuck = 0;
  bit     mon_in_hs, mon_out_hs, mon_out_valid, mon_in_ready;
  res_t   mon_res;
  bit     mon_b_valid, mon_b_in_ready;
  res_t   mon_b_res;
  int     run_len = 0;
  int     max_run = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [OPS_W-1:0] all_ops(input int v);
    logic [OPS_W-1:0] o;
    for (int k = 0; k < N_OPS; k++) o[k*OP_W +: OP_W] = OP_W'(v);
    return o;
  endfunction

  function automatic logic [OPS_W-1:0] rand_ops();
    logic [OPS_W-1:0] o;
    for (int k = 0; k < N_OPS; k++) o[k*OP_W +: OP_W] = OP_W'($urandom_range(0, (1 << OP_W) - 1));
    return o;
  endfunction

  function automatic longint ops_sum(input logic [OPS_W-1:0] o);
    longint s = 0;
    for (int k = 0; k < N_OPS; k++) s += longint'(o[k*OP_W +: OP_W]);
    return s;
  endfunction

  // One clock: observe at the falling edge, update the packet model, return just after the rise.
  task automatic step();
    res_t e;
    @(negedge clk);
    mon_in_hs       = a_if.in_valid && a_if.in_ready;
    mon_out_hs      = a_if.out_valid && a_if.out_ready;
    mon_out_valid   = a_if.out_valid;
    mon_in_ready    = a_if.in_ready;
    mon_res.sum     = longint'(a_if.out_sum);
    mon_res.fire    = longint'(a_if.out_fire);
    mon_res.ovf     = longint'(a_if.out_ovf);
    mon_res.beats   = longint'(a_if.out_beats);
    mon_b_valid     = b_if.out_valid;
    mon_b_in_ready  = b_if.in_ready;
    mon_b_res.sum   = longint'(b_if.out_sum);
    mon_b_res.fire  = longint'(b_if.out_fire);
    mon_b_res.ovf   = longint'(b_if.out_ovf);
    mon_b_res.beats = longint'(b_if.out_beats);
    if (mon_out_hs) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      $display("t=%0t result sum=%0d fire=%0d ovf=%0d beats=%0d",
               $time, mon_res.sum, mon_res.fire, mon_res.ovf, mon_res.beats);
    end else begin
      run_len = 0;
    end
    if (reset) begin
      exp_q.delete();
      pkt_total = 0;
      pkt_beats = 0;
    end else begin
      if (mon_out_hs) begin
        check("sb_result_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_sum", mon_res.sum, e.sum);
          check("sb_fire", mon_res.fire, e.fire);
          check("sb_ovf", mon_res.ovf, e.ovf);
          check("sb_beats", mon_res.beats, e.beats);
        end
      end
      if (mon_in_hs) begin
        pkt_total += ops_sum(a_if.in_ops);
        pkt_beats++;
        if (a_if.in_last) begin
          e.sum   = (pkt_total > SUM_MAX) ? SUM_MAX : pkt_total;
          e.ovf   = longint'(pkt_total > SUM_MAX);
          e.fire  = longint'(e.sum >= longint'(a_if.in_thresh));
          e.beats = (pkt_beats > BEAT_MAX) ? BEAT_MAX : pkt_beats;
          exp_q.push_back(e);
          pkt_total = 0;
          pkt_beats = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (ready_rand) a_if.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [OPS_W-1:0] ops, input bit last, input int thresh, output int waits);
    waits = 0;
    a_if.in_valid  = 1'b1;
    a_if.in_ops    = ops;
    a_if.in_last   = last;
    a_if.in_thresh = SUM_W'(thresh);
    step();
    while (!mon_in_hs && !stuck) begin
      waits++;
      if (waits > 1000) begin
        total++;
        bad++;
        stuck = 1;
        $display("FAIL send_timeout: waited %0d cycles, required acceptance within 1000", waits);
      end else begin
        step();
      end
    end
    a_if.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output bit got, output int edges);
    int n = 0;
    got = 0;
    while (n < 30 && !got) begin
      step();
      n++;
      got = mon_out_valid;
    end
    edges = n - 1;
    check({name, "_seen"}, longint'(got), 1);
  endtask

  task automatic b_packet(input string name, input int n, input int v, input int thresh,
                          input int exp_sum, input int exp_fire, input int exp_ovf, input int exp_beats);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      b_if.in_valid  = 1'b1;
      b_if.in_ops    = all_ops(v);
      b_if.in_last   = (i == n - 1);
      b_if.in_thresh = SUM_W_B'(thresh);
      step();
      check({name, "_in_ready"}, longint'(mon_b_in_ready), 1);
    end
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
    mon_b_valid = 0;
    while (k < 10 && !mon_b_valid) begin
      step();
      k++;
    end
    check({name, "_seen"}, longint'(mon_b_valid), 1);
    if (mon_b_valid) begin
      check({name, "_sum"}, mon_b_res.sum, exp_sum);
      check({name, "_fire"}, mon_b_res.fire, exp_fire);
      check({name, "_ovf"}, mon_b_res.ovf, exp_ovf);
      check({name, "_beats"}, mon_b_res.beats, exp_beats);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   w, edges, waitsum, len, beats_sent, pkt;
    bit   got;
    logic [OPS_W-1:0] ops5, ops9, ops3;

    tbl[0] = '{v: 7, thresh: 84,   exp_sum: 84, exp_fire: 1, exp_ovf: 0, exp_beats: 1};
    tbl[1] = '{v: 7, thresh: 85,   exp_sum: 84, exp_fire: 0, exp_ovf: 0, exp_beats: 1};
    tbl[2] = '{v: 0, thresh: 0,    exp_sum: 0,  exp_fire: 1, exp_ovf: 0, exp_beats: 1};
    tbl[3] = '{v: 1, thresh: 13,   exp_sum: 12, exp_fire: 0, exp_ovf: 0, exp_beats: 1};
    tbl[4] = '{v: 5, thresh: 60,   exp_sum: 60, exp_fire: 1, exp_ovf: 0, exp_beats: 1};
    tbl[5] = '{v: 3, thresh: 4095, exp_sum: 36, exp_fire: 0, exp_ovf: 0, exp_beats: 1};

    reset = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_ops = all_ops(7); a_if.in_last = 1'b1; a_if.in_thresh = '0;
    a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_ops = '0; b_if.in_last = 1'b0; b_if.in_thresh = '0;
    b_if.out_ready = 1'b1;

    // Reset state, with a beat offered that must not be taken.
    repeat (3) step();
    check("rst_in_ready", longint'(mon_in_ready), 0);
    check("rst_out_valid", longint'(mon_out_valid), 0);
    check("rst_out_sum", mon_res.sum, 0);
    check("rst_out_beats", mon_res.beats, 0);
    check("rst_out_ovf", mon_res.ovf, 0);
    reset = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.in_last = 1'b0;
    repeat (4) step();
    check("post_rst_in_ready", longint'(mon_in_ready), 1);
    check("post_rst_no_result", longint'(mon_out_valid), 0);

    // Single-beat table with latency check.
    for (int i = 0; i < 6; i++) begin
      send(all_ops(tbl[i].v), 1'b1, tbl[i].thresh, w);
      check("tbl_accept_wait", w, 0);
      wait_result("tbl", got, edges);
      if (got) begin
        check("tbl_latency_edges", edges, 2);
        check("tbl_sum", mon_res.sum, tbl[i].exp_sum);
        check("tbl_fire", mon_res.fire, tbl[i].exp_fire);
        check("tbl_ovf", mon_res.ovf, tbl[i].exp_ovf);
        check("tbl_beats", mon_res.beats, tbl[i].exp_beats);
      end
    end

    // Three-beat packet.
    send(all_ops(7), 1'b0, 0, w);
    send(all_ops(7), 1'b0, 0, w);
    send(all_ops(7), 1'b1, 252, w);
    wait_result("three", got, edges);
    if (got) begin
      check("three_sum", mon_res.sum, 252);
      check("three_beats", mon_res.beats, 3);
      check("three_fire", mon_res.fire, 1);
      check("three_ovf", mon_res.ovf, 0);
    end
    repeat (3) step();

    // Backpressure: results 5 and 9 held, a third beat waits for in_ready.
    ops5 = '0; ops5[2:0] = 3'd5;
    ops9 = '0; ops9[2:0] = 3'd7; ops9[5:3] = 3'd2;
    ops3 = '0; ops3[8:6] = 3'd3;
    a_if.out_ready = 1'b0;
    send(ops5, 1'b1, 0, w);
    send(ops9, 1'b1, 0, w);
    step();
    a_if.in_valid = 1'b1; a_if.in_ops = ops3; a_if.in_last = 1'b1; a_if.in_thresh = SUM_W'(4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_in_ready", longint'(mon_in_ready), 0);
      check("hold_out_valid", longint'(mon_out_valid), 1);
      check("hold_out_sum", mon_res.sum, 5);
    end
    a_if.out_ready = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    check("release_hs", longint'(mon_out_hs), 1);
    check("release_sum0", mon_res.sum, 5);
    check("release_accept3", longint'(mon_in_hs), 1);
    wait_result("release1", got, edges);
    if (got) check("release_sum1", mon_res.sum, 9);
    wait_result("release2", got, edges);
    if (got) begin
      check("release_sum2", mon_res.sum, 3);
      check("release_fire2", mon_res.fire, 0);
    end
    repeat (4) step();

    // Back-to-back single-beat packets.
    max_run = 0;
    waitsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(rand_ops(), 1'b1, $urandom_range(0, 84), w);
      waitsum += w;
    end
    repeat (6) step();
    check("b2b_waits", waitsum, 0);
    check("b2b_run", max_run, 8);

    // Reset in the middle of a packet discards the partial sum.
    send(all_ops(7), 1'b0, 0, w);
    send(all_ops(7), 1'b0, 0, w);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    send(all_ops(1), 1'b1, 12, w);
    wait_result("rstmid", got, edges);
    if (got) begin
      check("rstmid_sum", mon_res.sum, 12);
      check("rstmid_beats", mon_res.beats, 1);
      check("rstmid_ovf", mon_res.ovf, 0);
      check("rstmid_fire", mon_res.fire, 1);
    end
    repeat (3) step();

    // Narrow instance: saturation, overflow clear on next packet, beat-count saturation.
    b_packet("bsat", 4, 7, 200, 255, 1, 1, 3);
    b_packet("bzero", 1, 0, 0, 0, 1, 0, 1);
    b_packet("bbeats", 5, 1, 61, 60, 0, 0, 3);

    // Random sweep with random backpressure and idle gaps.
    ready_rand = 1;
    beats_sent = 0;
    pkt = 0;
    while (beats_sent < 10000 && !stuck) begin
      len = (pkt % 40 == 39) ? 60 : int'($urandom_range(1, 4));
      for (int b = 0; b < len && !stuck; b++) begin
        if ($urandom_range(0, 7) == 0) step();
        send(rand_ops(), (b == len - 1), int'($urandom_range(0, 300)), w);
        beats_sent++;
      end
      pkt++;
    end
    ready_rand = 0;
    a_if.out_ready = 1'b1;
    repeat (10) step();
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
